// File: rtl/w_ram_loader_pkg.sv
// -----------------------------------------------------------------------------
// w_ram_loader_pkg
// Shared constants and types for the mix-layer weight loader.
//   N_LEN   : width of one weight beat (and of the RAM row address)
//   DATA_N  : beats packed into one RAM row
//   HID_DIM : hidden dimension of the mix layer
//   ROW_W   : width of one packed RAM row
//   DEPTH   : rows written per load (W_1, W_2, W_3 back to back);
//             must satisfy DEPTH <= 2**N_LEN
//   wl_state_t : loader FSM encoding (IDLE=0, LOAD=1, DONE=2)
// -----------------------------------------------------------------------------
package w_ram_loader_pkg;

  localparam int N_LEN   = 8;
  localparam int DATA_N  = 4;
  localparam int HID_DIM = 8;

  localparam int ROW_W   = DATA_N * N_LEN;
  localparam int DEPTH   = 3 * (HID_DIM * HID_DIM / DATA_N);
  localparam int BEAT_CW = $clog2(DATA_N);

  typedef enum logic [1:0] {
    WL_IDLE = 2'd0,
    WL_LOAD = 2'd1,
    WL_DONE = 2'd2
  } wl_state_t;

  // A start pulse only opens a new load when no load is in progress.
  function automatic logic start_allowed(input wl_state_t s);
    return (s == WL_IDLE) || (s == WL_DONE);
  endfunction

endpackage

// File: rtl/w_ram_loader_if.sv
// -----------------------------------------------------------------------------
// w_ram_loader_if
// Bundle between the host/UART receive side (master) and the weight loader
// (slave), including the RAM write port the loader drives.
//   start              : one-cycle pulse, begins a load when loader is IDLE/DONE
//   in_valid/in_data   : weight beat offered by the host
//   in_ready           : loader can take a beat this cycle
//   we/waddr/wdata     : synchronous RAM write port (one we pulse per row)
//   busy/done          : loader status
//   checksum           : only with W_LOADER_CHECKSUM_EN defined
//
// Handshake: a beat transfers on a rising clk edge where in_valid && in_ready
// are both high. in_ready does not depend on in_valid; the host may raise or
// drop in_valid in any cycle, and the loader counts nothing without a transfer.
// -----------------------------------------------------------------------------
interface w_ram_loader_if;
  import w_ram_loader_pkg::*;

  logic             start;
  logic             in_valid;
  logic [N_LEN-1:0] in_data;
  logic             in_ready;
  logic             we;
  logic [N_LEN-1:0] waddr;
  logic [ROW_W-1:0] wdata;
  logic             busy;
  logic             done;
`ifdef W_LOADER_CHECKSUM_EN
  logic [N_LEN-1:0] checksum;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, we, waddr, wdata, busy, done, checksum
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, we, waddr, wdata, busy, done, checksum
  );
`else
  modport master (
    output start, in_valid, in_data,
    input  in_ready, we, waddr, wdata, busy, done
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, we, waddr, wdata, busy, done
  );
`endif

endinterface

// File: rtl/w_beat_packer.sv
// -----------------------------------------------------------------------------
// w_beat_packer
// Collects DATA_N beats into one row. Beat k of a row lands in lane k
// (bits [k*N_LEN +: N_LEN], lane 0 = LSBs).
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_clear       : restart at lane 0 (a new load is starting)
//   i_beat_vld    : a beat transfers this cycle
//   i_beat_data   : the beat
//   o_row_full    : one-cycle pulse, the transferring beat completes a row
//   o_row_data    : the completed row, valid while o_row_full is high
// -----------------------------------------------------------------------------
module w_beat_packer
  import w_ram_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_beat_vld,
  input  logic [N_LEN-1:0] i_beat_data,
  output logic             o_row_full,
  output logic [ROW_W-1:0] o_row_data
);

  // Only the first DATA_N-1 beats need storing; the last one is taken
  // straight from the input so the row is complete in the handshake cycle.
  localparam int                 SH_W      = ROW_W - N_LEN;
  localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(DATA_N - 1);
  localparam logic [BEAT_CW-1:0] BEAT_ONE  = BEAT_CW'(1);

  logic [BEAT_CW-1:0] r_beat_cnt;
  logic [SH_W-1:0]    r_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
      r_shift    <= '0;
    end else if (i_clear) begin
      r_beat_cnt <= '0;
      r_shift    <= '0;
    end else if (i_beat_vld) begin
      r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + BEAT_ONE;
      // Shift toward the LSBs: the oldest beat ends up in lane 0.
      r_shift    <= {i_beat_data, r_shift[SH_W-1:N_LEN]};
    end
  end

  assign o_row_full = i_beat_vld && (r_beat_cnt == LAST_BEAT);
  assign o_row_data = {i_beat_data, r_shift};

endmodule

// File: rtl/w_ram_loader.sv
// -----------------------------------------------------------------------------
// w_ram_loader
// Writer side of the mix-layer weight store. Accepts a stream of N_LEN-bit
// weight beats, packs DATA_N beats per row and writes DEPTH rows to the
// weight RAM starting at address 0 (W_1, W_2, W_3 back to back).
//   clk          : single clock, posedge
//   rst_n        : asynchronous active-low reset
//   bus          : w_ram_loader_if.slave (start, beat stream, RAM write port,
//                  busy/done, optional checksum)
//   o_dbg_state  : current FSM state
// Build option: define W_LOADER_CHECKSUM_EN to add bus.checksum, the sum
// modulo 2**N_LEN of every beat accepted since the last start.
// -----------------------------------------------------------------------------
module w_ram_loader
  import w_ram_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  w_ram_loader_if.slave    bus,
  output wl_state_t        o_dbg_state
);

  localparam logic [N_LEN-1:0] LAST_ROW = N_LEN'(DEPTH - 1);
  localparam logic [N_LEN-1:0] ROW_ONE  = N_LEN'(1);

  wl_state_t        r_state;
  wl_state_t        w_next_state;
  logic             w_in_ready;
  logic             w_busy;
  logic             w_done;

  logic             w_start_ok;
  logic             w_beat_hs;
  logic             w_row_full;
  logic [ROW_W-1:0] w_row_data;

  logic [N_LEN-1:0] r_row_cnt;
  logic             r_we;
  logic [N_LEN-1:0] r_waddr;
  logic [ROW_W-1:0] r_wdata;

  assign w_start_ok = bus.start && start_allowed(r_state);
  assign w_beat_hs  = bus.in_valid && w_in_ready;

  w_beat_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_start_ok),
    .i_beat_vld  (w_beat_hs),
    .i_beat_data (bus.in_data),
    .o_row_full  (w_row_full),
    .o_row_data  (w_row_data)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= WL_IDLE;
    else        r_state <= w_next_state;
  end

  // FSM next state and state-decoded outputs. Leaving LOAD on the final
  // row's handshake makes done rise together with that row's we pulse.
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      WL_IDLE: begin
        if (bus.start) w_next_state = WL_LOAD;
      end
      WL_LOAD: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        if (w_row_full && (r_row_cnt == LAST_ROW)) w_next_state = WL_DONE;
      end
      WL_DONE: begin
        w_done = 1'b1;
        if (bus.start) w_next_state = WL_LOAD;
      end
      default: w_next_state = WL_IDLE;
    endcase
  end

  // Row counter and RAM write port. The write is registered one cycle after
  // the completing beat; the packer already accepts the next row meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_cnt <= '0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
    end else begin
      r_we <= w_row_full;
      if (w_start_ok) begin
        r_row_cnt <= '0;
      end else if (w_row_full) begin
        r_row_cnt <= r_row_cnt + ROW_ONE;
        r_waddr   <= r_row_cnt;
        r_wdata   <= w_row_data;
      end
    end
  end

`ifdef W_LOADER_CHECKSUM_EN
  logic [N_LEN-1:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_checksum <= '0;
    else if (w_start_ok) r_checksum <= '0;
    else if (w_beat_hs)  r_checksum <= r_checksum + bus.in_data;
  end

  assign bus.checksum = r_checksum;
`endif

  assign bus.in_ready = w_in_ready;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.we       = r_we;
  assign bus.waddr    = r_waddr;
  assign bus.wdata    = r_wdata;
  assign o_dbg_state  = r_state;

endmodule
